// File: rtl/imem_loader_10bit_64word.sv
// rtl/imem_loader_10bit_64word.sv - writable 10x64 instruction memory with host program loader
// Optional appended checksum word and ERR flag: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader_10bit_64word #(
  parameter int AW = 6,
  parameter int DW = 10,
  parameter logic [DW-1:0] FILL_WORD = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] LEN,
  input  logic [DW-1:0] DIN,
  input  logic          DVALID,
  output logic          DREADY,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic          CPU_RST,
  input  logic [AW-1:0] AD,
  output logic [DW-1:0] Q
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, FILL, FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wp_q;
  logic [AW:0]   count_q;
  logic          hold_q;
  logic          accept;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem [DEPTH];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DW-1:0] sum_q;
  logic          err_q;
`endif

  assign DREADY  = (state_q == LOAD) || (state_q == CHECK);
  assign BUSY    = (state_q != IDLE);
  assign DONE    = (state_q == FIN);
  assign CPU_RST = hold_q || (state_q != IDLE);
  assign accept  = DVALID && DREADY;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_wdata = DIN;
    case (state_q)
      IDLE: if (START) state_d = LOAD;
      LOAD: begin
        if (accept) begin
          mem_we = 1'b1;
          if (count_q == (AW+1)'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            // A full 64-word program leaves nothing to pad.
            state_d = (wp_q == LAST_ADDR) ? FIN : FILL;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      // WP has wrapped to 0 only when every word was loaded.
      CHECK: if (accept) state_d = (wp_q == '0) ? FIN : FILL;
`endif
      FILL: begin
        mem_we    = 1'b1;
        mem_wdata = FILL_WORD;
        if (wp_q == LAST_ADDR) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wp_q    <= '0;
      count_q <= '0;
      hold_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && START) begin
        wp_q    <= '0;
        count_q <= (LEN == '0) ? (AW+1)'(DEPTH) : {1'b0, LEN};
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q   <= '0;
        err_q   <= 1'b0;
`endif
      end
      if (mem_we) wp_q <= wp_q + AW'(1);
      if (state_q == LOAD && accept) begin
        count_q <= count_q - (AW+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q   <= sum_q + DIN;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state_q == CHECK && accept && DIN != sum_q) err_q <= 1'b1;
      if (state_q == FIN) hold_q <= err_q;
`else
      if (state_q == FIN) hold_q <= 1'b0;
`endif
    end
  end

  // Contents survive RST; a reset cycle suppresses any in-flight write.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) mem[wp_q] <= mem_wdata;
  end

  assign Q = mem[AD];

endmodule
